// File: rtl/vid_out_axi4s_pkg.sv
// Shared encodings for the AXI4-Stream to native video output bridge:
// FSM state encoding and ERR bit positions.
package vid_out_axi4s_pkg;
    typedef enum logic [1:0] {
        ST_FLUSH    = 2'd0,
        ST_WAIT_VTG = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam int ERR_W         = 5;
    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_EOL_EARLY = 1;
    localparam int ERR_EOL_LATE  = 2;
    localparam int ERR_SOF_EARLY = 3;
    localparam int ERR_SOF_LATE  = 4;
endpackage

// File: rtl/vid_out_axi4s_sync_if.sv
// Bundle of stream input, timing-generator input, native video output and
// status signals of the video output bridge.
interface vid_out_axi4s_sync_if import vid_out_axi4s_pkg::*; #(
    parameter int C_DATA_WIDTH = 24
) ();
    logic                    ACLKEN;
    logic [C_DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic                    S_AXIS_TVALID;
    logic                    S_AXIS_TUSER;
    logic                    S_AXIS_TLAST;
    logic                    S_AXIS_TREADY;
    logic                    VTG_ACTIVE_VIDEO;
    logic                    VTG_VBLANK;
    logic                    VTG_HBLANK;
    logic                    VTG_VSYNC;
    logic                    VTG_HSYNC;
    logic [C_DATA_WIDTH-1:0] VID_DATA;
    logic                    VID_ACTIVE_VIDEO;
    logic                    VID_VBLANK;
    logic                    VID_HBLANK;
    logic                    VID_VSYNC;
    logic                    VID_HSYNC;
    logic                    LOCKED;
    logic [ERR_W-1:0]        ERR;

    modport slave (
        input  ACLKEN, S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TUSER, S_AXIS_TLAST,
        input  VTG_ACTIVE_VIDEO, VTG_VBLANK, VTG_HBLANK, VTG_VSYNC, VTG_HSYNC,
        output S_AXIS_TREADY, VID_DATA, VID_ACTIVE_VIDEO, VID_VBLANK, VID_HBLANK,
        output VID_VSYNC, VID_HSYNC, LOCKED, ERR
    );

    modport master (
        output ACLKEN, S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TUSER, S_AXIS_TLAST,
        output VTG_ACTIVE_VIDEO, VTG_VBLANK, VTG_HBLANK, VTG_VSYNC, VTG_HSYNC,
        input  S_AXIS_TREADY, VID_DATA, VID_ACTIVE_VIDEO, VID_VBLANK, VID_HBLANK,
        input  VID_VSYNC, VID_HSYNC, LOCKED, ERR
    );
endinterface

// File: rtl/vid_out_axi4s_align_chk.sv
// Stream/timing alignment checker: flags SOF and EOL misplacement and
// underflow while the bridge is locked.
module vid_out_axi4s_align_chk import vid_out_axi4s_pkg::*; (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             locked_i,
    input  logic             active_i,
    input  logic             prev_active_i,
    input  logic             first_px_i,
    input  logic             tvalid_i,
    input  logic             tuser_i,
    input  logic             tlast_i,
    input  logic             beat_i,
    output logic [ERR_W-1:0] err_o,
    output logic             sof_blk_o
);
    logic last_q, last_d;           // TLAST of the most recent consumed beat
    logic cons_last_q, cons_last_d; // previous enabled cycle consumed an EOL beat

    assign last_d      = beat_i ? tlast_i : last_q;
    assign cons_last_d = beat_i & tlast_i;

    always_comb begin
        err_o                = '0;
        err_o[ERR_UNDERFLOW] = locked_i & active_i & ~tvalid_i;
        err_o[ERR_SOF_EARLY] = locked_i & active_i & tvalid_i & tuser_i & ~first_px_i;
        err_o[ERR_SOF_LATE]  = locked_i & active_i & tvalid_i & ~tuser_i & first_px_i;
        err_o[ERR_EOL_EARLY] = locked_i & active_i & cons_last_q;
        err_o[ERR_EOL_LATE]  = locked_i & prev_active_i & ~active_i & ~last_q;
    end

    // Misplaced SOF beats are left in the stream for the flush to resolve.
    assign sof_blk_o = err_o[ERR_SOF_EARLY] | err_o[ERR_SOF_LATE];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q      <= 1'b0;
            cons_last_q <= 1'b0;
        end else if (en_i) begin
            last_q      <= last_d;
            cons_last_q <= cons_last_d;
        end
    end
endmodule

// File: rtl/vid_out_axi4s_sync.sv
// AXI4-Stream to native video bridge: aligns the stream SOF to the timing
// generator's first active pixel and re-registers timing with pixel data.
module vid_out_axi4s_sync import vid_out_axi4s_pkg::*; #(
    parameter int C_DATA_WIDTH = 24
) (
    input logic           ACLK,
    input logic           ARESETN,
    vid_out_axi4s_sync_if.slave bus
);
    state_t                  state_q, state_d;
    logic                    vbs_q, vbs_d;
    logic [C_DATA_WIDTH-1:0] data_q, data_d;
    logic [4:0]              tim_q;
    logic                    locked_q;
    logic [ERR_W-1:0]        err_q, err_c;
    logic                    rdy_c, beat, sof_blk, in_lock;

    assign in_lock = (state_q == ST_LOCKED);
    assign beat    = rdy_c & bus.S_AXIS_TVALID;

    vid_out_axi4s_align_chk u_chk (
        .clk_i         (ACLK),
        .rst_ni        (ARESETN),
        .en_i          (bus.ACLKEN),
        .locked_i      (in_lock),
        .active_i      (bus.VTG_ACTIVE_VIDEO),
        .prev_active_i (tim_q[4]),
        .first_px_i    (vbs_q),
        .tvalid_i      (bus.S_AXIS_TVALID),
        .tuser_i       (bus.S_AXIS_TUSER),
        .tlast_i       (bus.S_AXIS_TLAST),
        .beat_i        (beat),
        .err_o         (err_c),
        .sof_blk_o     (sof_blk)
    );

    always_comb begin
        state_d = state_q;
        rdy_c   = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                rdy_c = ~bus.S_AXIS_TUSER;
                if (bus.S_AXIS_TVALID && bus.S_AXIS_TUSER) state_d = ST_WAIT_VTG;
            end
            ST_WAIT_VTG: begin
                rdy_c = bus.VTG_ACTIVE_VIDEO & vbs_q;
                if (rdy_c && bus.S_AXIS_TVALID) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                rdy_c = bus.VTG_ACTIVE_VIDEO & ~sof_blk;
                if (|err_c) state_d = ST_FLUSH;
            end
            default: state_d = ST_FLUSH;
        endcase
        if (!bus.ACLKEN) begin
            rdy_c   = 1'b0;
            state_d = state_q;
        end
    end

    // vbs_q marks "vblank seen since the last active cycle", i.e. the next
    // active cycle is the first pixel of a frame.
    always_comb begin
        vbs_d = vbs_q;
        if (state_d == ST_FLUSH && state_q != ST_FLUSH) vbs_d = 1'b0;
        else if (bus.VTG_VBLANK)                        vbs_d = 1'b1;
        else if (bus.VTG_ACTIVE_VIDEO)                  vbs_d = 1'b0;
    end

    assign data_d = beat ? bus.S_AXIS_TDATA : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_FLUSH;
            vbs_q    <= 1'b0;
            data_q   <= '0;
            tim_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else if (bus.ACLKEN) begin
            state_q  <= state_d;
            vbs_q    <= vbs_d;
            data_q   <= data_d;
            tim_q    <= {bus.VTG_ACTIVE_VIDEO, bus.VTG_VBLANK, bus.VTG_HBLANK,
                         bus.VTG_VSYNC, bus.VTG_HSYNC};
            locked_q <= (state_d == ST_LOCKED);
            err_q    <= err_c;
        end
    end

    assign bus.S_AXIS_TREADY    = rdy_c & ARESETN;
    assign bus.VID_DATA         = data_q;
    assign bus.VID_ACTIVE_VIDEO = tim_q[4];
    assign bus.VID_VBLANK       = tim_q[3];
    assign bus.VID_HBLANK       = tim_q[2];
    assign bus.VID_VSYNC        = tim_q[1];
    assign bus.VID_HSYNC        = tim_q[0];
    assign bus.LOCKED           = locked_q;
    assign bus.ERR              = err_q;
endmodule

// File: doc/vid_out_axi4s_sync.md
VID_OUT_AXI4S_SYNC -- requirements
Module: vid_out_axi4s_sync

Interface
REQ-001 The block SHALL have parameter C_DATA_WIDTH, default 24, giving the width of AXI4-Stream tdata and of native video data.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset. Ports: ACLK in 1, the clock; ARESETN in 1, reset.
REQ-003 The block SHALL have these AXI4-Stream and enable inputs:
- ACLKEN in 1, clock enable.
- S_AXIS_TDATA in C_DATA_WIDTH, pixel data.
- S_AXIS_TVALID in 1, beat valid.
- S_AXIS_TUSER in 1, start of frame (SOF).
- S_AXIS_TLAST in 1, end of line (EOL).
REQ-004 The block SHALL have S_AXIS_TREADY out 1, beat accepted.
REQ-005 The block SHALL have timing-generator inputs in the ACLK domain, each in 1: VTG_ACTIVE_VIDEO, VTG_VBLANK, VTG_HBLANK, VTG_VSYNC, VTG_HSYNC.
REQ-006 The block SHALL have native video outputs: VID_DATA out C_DATA_WIDTH; VID_ACTIVE_VIDEO, VID_VBLANK, VID_HBLANK, VID_VSYNC, VID_HSYNC out 1 each.
REQ-007 The block SHALL have status outputs: LOCKED out 1; ERR out 5, single-cycle pulses with bits [0] UNDERFLOW, [1] EOL_EARLY, [2] EOL_LATE, [3] SOF_EARLY, [4] SOF_LATE.

Function
REQ-008 A beat SHALL be consumed only when S_AXIS_TVALID, S_AXIS_TREADY and ACLKEN are all 1; S_AXIS_TREADY SHALL be combinational from the state and the inputs.
REQ-009 While ACLKEN=0, all registers SHALL hold and S_AXIS_TREADY SHALL be 0.
REQ-010 The state machine SHALL have three states: FLUSH, WAIT_VTG and LOCKED.
REQ-011 FLUSH: S_AXIS_TREADY = ~S_AXIS_TUSER; non-SOF beats are discarded; a valid SOF beat is held unconsumed and the state goes to WAIT_VTG.
REQ-012 WAIT_VTG: S_AXIS_TREADY=0 until a vblank_seen flag is set (set by VTG_VBLANK=1).
REQ-013 In WAIT_VTG, on the first VTG_ACTIVE_VIDEO=1 cycle with vblank_seen set, S_AXIS_TREADY SHALL be 1, the SOF beat SHALL be consumed and the state SHALL go to LOCKED.
REQ-014 LOCKED: S_AXIS_TREADY = VTG_ACTIVE_VIDEO; exactly one beat is consumed per active cycle.
REQ-015 VID_* timing outputs SHALL be VTG_* inputs delayed by one enabled cycle, in every state.
REQ-016 VID_DATA SHALL be the consumed tdata, registered in the same cycle as the timing signals; it SHALL be 0 when no beat is consumed.
REQ-017 LOCKED output SHALL be 1 exactly while the state is LOCKED, registered.
REQ-018 The first-pixel position is the first active cycle after any VTG_VBLANK=1 cycle.
REQ-019 SOF_EARLY: in LOCKED, a beat with TUSER=1 at a non-first-pixel active cycle SHALL NOT be consumed; pulse ERR[3]; go to FLUSH.
REQ-020 SOF_LATE: in LOCKED, TUSER=0 at the first-pixel position SHALL NOT be consumed; pulse ERR[4]; go to FLUSH.
REQ-021 UNDERFLOW: in LOCKED, VTG_ACTIVE_VIDEO=1 with TVALID=0 SHALL pulse ERR[0], output VID_DATA=0 and go to FLUSH.
REQ-022 EOL_EARLY: a consumed beat with TLAST=1 while VTG_ACTIVE_VIDEO=1 on the next enabled cycle SHALL pulse ERR[1] and go to FLUSH.
REQ-023 EOL_LATE: VTG_ACTIVE_VIDEO falling while the last consumed beat had TLAST=0 SHALL pulse ERR[2] and go to FLUSH.
REQ-024 Simultaneous error conditions SHALL each pulse their own ERR bit in the same cycle, with a single transition to FLUSH.
REQ-025 Entering FLUSH SHALL clear vblank_seen.
REQ-026 Errors SHALL NOT be flagged in FLUSH or WAIT_VTG.

Reset
REQ-027 While ARESETN=0, the state SHALL be FLUSH and vblank_seen SHALL be 0.
REQ-028 While ARESETN=0, all outputs SHALL be 0, including S_AXIS_TREADY.
REQ-029 Reset assertion mid-frame SHALL take effect immediately (asynchronously); after deassertion, operation resumes from FLUSH.
REQ-030 Outputs after deassertion SHALL depend only on the inputs sampled after deassertion.

Structure
REQ-031 Package vid_out_axi4s_pkg SHALL hold the state encoding and the ERR bit index constants.
REQ-032 Error detection (REQ-019..REQ-024) SHALL live in sub-module vid_out_axi4s_align_chk; the FSM and datapath SHALL stay in the top level.

Verification
REQ-033 Lock: 8x4 frame with vblank of 2 lines and hblank of 4 cycles, stream ready -> LOCKED=1 at the first active pixel; VID_DATA equals pixels 0..31 in order, 1 cycle after VTG_ACTIVE_VIDEO; ERR=0 for 3 frames.
REQ-034 Flush: 5 stray non-SOF beats before the SOF -> all 5 consumed in FLUSH and never output; the SOF pixel appears at the first active cycle of the next frame.
REQ-035 Underflow: TVALID=0 for one active cycle at line 1 pixel 3 -> ERR=5'b00001 pulse; VID_DATA=0 that cycle; LOCKED falls next cycle; relock at the next frame.
REQ-036 EOL errors: TLAST on pixel 6 of an 8-pixel line -> ERR[1] pulse; TLAST missing on pixel 7 -> ERR[2] pulse; both cases go to FLUSH.
REQ-037 SOF errors: TUSER=1 on line 2 pixel 0 -> ERR[3], beat not consumed, then WAIT_VTG; TUSER=0 at the first pixel -> ERR[4].
REQ-038 ACLKEN and reset: toggling ACLKEN 1/0 each cycle -> identical output sequence at half rate; ARESETN pulsed low mid-line -> all outputs 0 immediately, relock at the next frame.
